ram_block_copier: RTL
=====================

Name: ram_block_copier

Overview:
Master-side controller for dualport_ram that copies a contiguous block of words from one RAM region to another.
- Read side uses RAM port 1: read-only, write_en1 tied low.
- Write side uses RAM port 2: write-only, read_en2 tied low.
- Pipelined so one word moves per clock.
- Sits between the processor's control logic and the RAM, offloading memcpy-style transfers.

Parameters:
ADDR_W, 9, RAM address width; address space is 2^ADDR_W words
DATA_W, 16, RAM word width
LEN_W, 10, width of the length input; must hold 2^ADDR_W

Ports:
clk  input  1  system clock; everything is rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request; sampled only in IDLE.
src_addr  input  ADDR_W  first source word address; sampled with start.
dst_addr  input  ADDR_W  first destination word address; sampled with start.
length  input  LEN_W  number of words to copy; sampled with start.
busy  output  1  high while a copy is in progress.
done  output  1  one-cycle pulse when a copy completes.
checksum  output  DATA_W  running sum of copied words (see Optional Feature).
addr1  output  ADDR_W  RAM port 1 address.
read_en1  output  1  RAM port 1 read enable.
write_en1  output  1  constant 0.
Data_out1  input  DATA_W  RAM port 1 read data; valid the cycle after read_en1.
addr2  output  ADDR_W  RAM port 2 address.
write_en2  output  1  RAM port 2 write enable.
read_en2  output  1  constant 0.
Data_in2  output  DATA_W  RAM port 2 write data.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - busy, done, read_en1, write_en2 = 0.
  - addr1, addr2, Data_in2, checksum = 0.
  - All internal counters = 0.
- Reset mid-copy aborts the copy immediately; words already written stay in the RAM.
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE:
  - start=1 with length!=0: latch the inputs; go to READ.
  - start=1 with length=0: go to FIN, with no RAM access.
  - length > 2^ADDR_W is clamped to 2^ADDR_W.
- Timing, with start sampled at edge k and latched length L:
  - Read i (i=0..L-1): read_en1=1, addr1=src+i, in cycle k+1+i.
  - Write i: write_en2=1, addr2=dst+i, Data_in2=Data_out1, in cycle k+2+i.
  - Data_in2 is a combinational pass-through of Data_out1, qualified by write_en2.
  - READ lasts L cycles. DRAIN lasts 1 cycle and carries the last write. FIN lasts 1 cycle with done=1. Then IDLE.
  - busy=1 in READ, DRAIN and FIN.
  - Length-0 request: done in cycle k+1, busy=1 only in that cycle.
- Address arithmetic is modulo 2^ADDR_W; src+i and dst+i wrap silently (e.g. 511 -> 0).
- start while busy is ignored; no queuing.
- Overlap: the copy is always forward.
  - dst <= src, or non-overlapping regions: exact copy.
  - dst in (src, src+L-1]: destination contents are undefined. Caller is responsible for avoiding this.
- read_en1 and write_en2 are never high outside READ/DRAIN. write_en1 and read_en2 are always 0.
- done never overlaps with a new copy. A new start is accepted in the cycle after FIN.

Optional Feature:
Macro: COPIER_CHECKSUM_EN.
- Defined:
  - checksum clears to 0 when a start is accepted.
  - On every write_en2 cycle, checksum += Data_in2, modulo 2^DATA_W.
  - Final value is stable from the FIN cycle until the next accepted start.
- Undefined: checksum is constant 0 and no accumulator logic is built.

Test Plan:
- Basic copy:
  - Preload RAM[1..3]=1,4,8.
  - Stimulus: start, src=1, dst=10, length=3.
  - Expect: reads at 1,2,3 in consecutive cycles; writes RAM[10..12]=1,4,8 one cycle behind; done exactly 5 cycles after the start edge.
  - With COPIER_CHECKSUM_EN: checksum=13.
- Wrap-around:
  - Preload RAM[510]=7, RAM[511]=9, RAM[0]=10.
  - Stimulus: src=510, dst=100, length=3.
  - Expect: RAM[100..102]=7,9,10; addr1 sequence 510,511,0.
- Zero length:
  - Stimulus: start, length=0.
  - Expect: done in the next cycle; read_en1/write_en2 never asserted; RAM unchanged.
- Start while busy:
  - Stimulus: second start (src=200) two cycles into a 4-word copy.
  - Expect: ignored; only the first copy's addresses appear; exactly one done pulse.
- Mid-copy reset:
  - Stimulus: rst asserted during the third cycle of an 8-word copy.
  - Expect: outputs 0 in the same cycle; at most 2 destination words written; after release a fresh copy completes normally.
- Full-size copy:
  - Stimulus: length=512, src=0, dst=0.
  - Expect: 512 reads/writes, RAM unchanged, busy high for 514 cycles.
  - With COPIER_CHECKSUM_EN: checksum equals the modular sum of all RAM words.

Source files
------------

// File: rtl/ram_block_copier.sv
// ram_block_copier: copies a block of RAM words from port 1 (read) to port 2 (write), one word per clock.
// Define COPIER_CHECKSUM_EN to build the running checksum of copied words; otherwise checksum is tied to 0.
module ram_block_copier #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] addr1,
  output logic              read_en1,
  output logic              write_en1,
  input  logic [DATA_W-1:0] Data_out1,
  output logic [ADDR_W-1:0] addr2,
  output logic              write_en2,
  output logic              read_en2,
  output logic [DATA_W-1:0] Data_in2
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | one read per cycle; the word read last cycle is written
  // DRAIN | final write only
  // FIN   | copy complete, done pulse
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

  state_t            state, state_nxt;
  logic              start_ok;
  logic [LEN_W-1:0]  len_clamp;
  logic [LEN_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_pend;

  assign start_ok  = (state == IDLE) && start;
  assign len_clamp = (length > MAX_LEN) ? MAX_LEN : length;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (length == '0) ? FIN : READ;
      READ:    if (rd_cnt == '0) state_nxt = DRAIN;
      DRAIN:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    read_en1  = 1'b0;
    write_en2 = wr_pend;
    case (state)
      READ: begin
        busy     = 1'b1;
        read_en1 = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // rd_cnt holds reads remaining after the current one; zero marks the last read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= (state == READ);
      if (start_ok) begin
        rd_cnt  <= len_clamp - 1'b1;
        rd_addr <= src_addr;
        wr_addr <= dst_addr;
      end else begin
        if (state == READ) begin
          rd_addr <= rd_addr + 1'b1;
          if (rd_cnt != '0) rd_cnt <= rd_cnt - 1'b1;
        end
        if (wr_pend) wr_addr <= wr_addr + 1'b1;
      end
    end
  end

  assign addr1     = rd_addr;
  assign addr2     = wr_addr;
  assign write_en1 = 1'b0;
  assign read_en2  = 1'b0;
  assign Data_in2  = write_en2 ? Data_out1 : '0;

`ifdef COPIER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            sum_q <= '0;
    else if (start_ok)  sum_q <= '0;
    else if (write_en2) sum_q <= sum_q + Data_in2;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule
